// File: rtl/soc_system_pio_irq_gen2.sv
// Avalon-MM bidirectional PIO with input synchronisation, per-bit edge capture,
// interrupt mask and a level interrupt built only from registered state.
module soc_system_pio_irq_gen2 #(
    parameter int unsigned      WIDTH       = 32,
    parameter logic [WIDTH-1:0] RESET_OUT   = {WIDTH{1'b0}},
    parameter int unsigned      EDGE_TYPE   = 0,
    parameter int unsigned      SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic             irq
);

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_OUT     = 3'd1;
    localparam logic [2:0] ADDR_MASK    = 3'd2;
    localparam logic [2:0] ADDR_EDGECAP = 3'd3;
    localparam logic [2:0] ADDR_OUTSET  = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR  = 3'd5;

    logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_out;
    logic [WIDTH-1:0] r_mask;
    logic [WIDTH-1:0] r_edgecap;
    logic [31:0]      r_readdata;

    logic             w_wr;
    logic [WIDTH-1:0] w_wdata;
    logic [WIDTH-1:0] w_sync_s;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_clr;
    logic [WIDTH-1:0] w_rd_field;
    logic [31:0]      w_rd_mux;
    logic             w_unused_wdata;

    assign w_wr           = chipselect & ~write_n;
    assign w_wdata        = writedata[WIDTH-1:0];
    assign w_unused_wdata = ^{1'b0, writedata};
    assign w_sync_s       = r_sync[SYNC_STAGES-1];

    // Input synchroniser chain plus one delay flop for edge detection
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_sync[i] <= {WIDTH{1'b0}};
            end
            r_prev <= {WIDTH{1'b0}};
        end else begin
            r_sync[0] <= in_port;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_sync[i] <= r_sync[i-1];
            end
            r_prev <= w_sync_s;
        end
    end

    // Edge selection by capture mode; any unknown mode behaves as any-edge
    always_comb begin
        w_edge = {WIDTH{1'b0}};
        case (EDGE_TYPE)
            32'd0:   w_edge = w_sync_s & ~r_prev;
            32'd1:   w_edge = ~w_sync_s & r_prev;
            default: w_edge = w_sync_s ^ r_prev;
        endcase
    end

    // Write-1-to-clear mask for the capture register
    always_comb begin
        w_clr = {WIDTH{1'b0}};
        if (w_wr && (address == ADDR_EDGECAP)) begin
            w_clr = w_wdata;
        end else begin
            w_clr = {WIDTH{1'b0}};
        end
    end

    // Edge capture: a new edge overrides a same-cycle clear
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_edgecap <= {WIDTH{1'b0}};
        end else begin
            r_edgecap <= (r_edgecap & ~w_clr) | w_edge;
        end
    end

    // Output register with direct, set and clear write ports
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out <= RESET_OUT;
        end else if (w_wr) begin
            case (address)
                ADDR_DATA:   r_out <= w_wdata;
                ADDR_OUTSET: r_out <= r_out | w_wdata;
                ADDR_OUTCLR: r_out <= r_out & ~w_wdata;
                default:     r_out <= r_out;
            endcase
        end else begin
            r_out <= r_out;
        end
    end

    // Interrupt mask register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mask <= {WIDTH{1'b0}};
        end else if (w_wr && (address == ADDR_MASK)) begin
            r_mask <= w_wdata;
        end else begin
            r_mask <= r_mask;
        end
    end

    // Read mux; set/clear ports and unmapped words read as zero
    always_comb begin
        w_rd_field = {WIDTH{1'b0}};
        case (address)
            ADDR_DATA:    w_rd_field = w_sync_s;
            ADDR_OUT:     w_rd_field = r_out;
            ADDR_MASK:    w_rd_field = r_mask;
            ADDR_EDGECAP: w_rd_field = r_edgecap;
            default:      w_rd_field = {WIDTH{1'b0}};
        endcase
        w_rd_mux = 32'd0;
        w_rd_mux[WIDTH-1:0] = w_rd_field;
    end

    // Read data is refreshed every cycle regardless of chipselect
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_readdata <= 32'd0;
        end else begin
            r_readdata <= w_rd_mux;
        end
    end

    assign readdata = r_readdata;
    assign out_port = r_out;
    // Combines registers only, so it cannot glitch on input activity
    assign irq      = |(r_edgecap & r_mask);

endmodule

// File: tb/tb_soc_system_pio_irq_gen2.sv
// Self-checking bench: two 8-bit instances (rising-edge and any-edge capture)
// on a shared bus, read results checked through an expected-value queue.
module tb_soc_system_pio_irq_gen2;

    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        cs0;
    logic        cs2;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] rd0;
    logic [31:0] rd2;
    logic [7:0]  in0;
    logic [7:0]  in2;
    logic [7:0]  out0;
    logic [7:0]  out2;
    logic        irq0;
    logic        irq2;

    int unsigned vectors;
    int unsigned miscompares;
    logic [31:0] exp_q [$];
    logic [31:0] got;
    logic [31:0] exp;

    soc_system_pio_irq_gen2 #(.WIDTH(8), .RESET_OUT(8'hA5), .EDGE_TYPE(0), .SYNC_STAGES(2)) dut0 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs0),
        .write_n(write_n), .writedata(writedata), .readdata(rd0),
        .in_port(in0), .out_port(out0), .irq(irq0)
    );

    soc_system_pio_irq_gen2 #(.WIDTH(8), .RESET_OUT(8'h00), .EDGE_TYPE(2), .SYNC_STAGES(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs2),
        .write_n(write_n), .writedata(writedata), .readdata(rd2),
        .in_port(in2), .out_port(out2), .irq(irq2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_write(input logic s0, input logic s2, input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        cs0 = s0; cs2 = s2; address = a; writedata = d; write_n = 1'b0;
        @(posedge clk);
        #1;
        cs0 = 1'b0; cs2 = 1'b0; write_n = 1'b1;
    endtask

    task automatic do_read(input logic [2:0] a);
        @(negedge clk);
        cs0 = 1'b1; cs2 = 1'b1; address = a; write_n = 1'b1;
        @(posedge clk);
        #1;
        cs0 = 1'b0; cs2 = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        vectors++;
        if (out0 !== 8'hA5) begin miscompares++; $display("FAIL reset_out_port: got %h want a5", out0); end
        vectors++;
        if (irq0 !== 1'b0 || irq2 !== 1'b0) begin miscompares++; $display("FAIL reset_irq: got %b%b want 00", irq0, irq2); end
        exp_q.push_back(32'h0000_00A5);
        do_read(3'd1);
        got = rd0; exp = exp_q.pop_front(); vectors++;
        if (got !== exp) begin miscompares++; $display("FAIL reset_out_read: got %h want %h", got, exp); end
        exp_q.push_back(32'h0000_0000);
        do_read(3'd3);
        got = rd0; exp = exp_q.pop_front(); vectors++;
        if (got !== exp) begin miscompares++; $display("FAIL reset_edgecap_read: got %h want %h", got, exp); end
    endtask

    task automatic test_out_regs();
        logic [7:0] seq_data [3];
        logic [2:0] seq_addr [3];
        logic [7:0] seq_exp  [3];
        seq_data = '{8'h3C, 8'h01, 8'h0C};
        seq_addr = '{3'd0, 3'd4, 3'd5};
        seq_exp  = '{8'h3C, 8'h3D, 8'h31};
        for (int i = 0; i < 3; i++) begin
            do_write(1'b1, 1'b0, seq_addr[i], (i == 0) ? 32'hFFFF_FF3C : {24'hFFFF_FF, seq_data[i]});
            vectors++;
            if (out0 !== seq_exp[i]) begin miscompares++; $display("FAIL out_seq%0d: got %h want %h", i, out0, seq_exp[i]); end
        end
        do_write(1'b1, 1'b0, 3'd1, 32'h0000_00FF);
        exp_q.push_back(32'h0000_0031);
        do_read(3'd1);
        got = rd0; exp = exp_q.pop_front(); vectors++;
        if (got !== exp) begin miscompares++; $display("FAIL out_readback: got %h want %h", got, exp); end
        for (int a = 4; a < 8; a++) begin
            exp_q.push_back(32'h0000_0000);
            do_read(a[2:0]);
            got = rd0; exp = exp_q.pop_front(); vectors++;
            if (got !== exp) begin miscompares++; $display("FAIL zero_read_addr%0d: got %h want %h", a, got, exp); end
        end
    endtask

    task automatic test_rise_capture();
        do_write(1'b1, 1'b0, 3'd2, 32'h0000_0002);
        exp_q.push_back(32'h0000_0002);
        do_read(3'd2);
        got = rd0; exp = exp_q.pop_front(); vectors++;
        if (got !== exp) begin miscompares++; $display("FAIL mask_read: got %h want %h", got, exp); end
        @(negedge clk);
        in0 = 8'h02;
        @(posedge clk); #1;
        @(posedge clk); #1;
        vectors++;
        if (irq0 !== 1'b0) begin miscompares++; $display("FAIL irq_early: got %b want 0", irq0); end
        @(posedge clk); #1;
        vectors++;
        if (irq0 !== 1'b1) begin miscompares++; $display("FAIL irq_rise: got %b want 1", irq0); end
        exp_q.push_back(32'h0000_0002);
        do_read(3'd0);
        got = rd0; exp = exp_q.pop_front(); vectors++;
        if (got !== exp) begin miscompares++; $display("FAIL data_read: got %h want %h", got, exp); end
        @(negedge clk);
        in0 = 8'h00;
        repeat (4) @(posedge clk);
        exp_q.push_back(32'h0000_0002);
        do_read(3'd3);
        got = rd0; exp = exp_q.pop_front(); vectors++;
        if (got !== exp) begin miscompares++; $display("FAIL edgecap_after_fall: got %h want %h", got, exp); end
        do_write(1'b1, 1'b0, 3'd3, 32'h0000_0002);
        vectors++;
        if (irq0 !== 1'b0) begin miscompares++; $display("FAIL irq_after_clear: got %b want 0", irq0); end
        exp_q.push_back(32'h0000_0000);
        do_read(3'd3);
        got = rd0; exp = exp_q.pop_front(); vectors++;
        if (got !== exp) begin miscompares++; $display("FAIL edgecap_cleared: got %h want %h", got, exp); end
    endtask

    task automatic test_clear_collision();
        @(negedge clk);
        in0 = 8'h04;
        @(posedge clk);
        @(posedge clk);
        do_write(1'b1, 1'b0, 3'd3, 32'h0000_0004);
        exp_q.push_back(32'h0000_0004);
        do_read(3'd3);
        got = rd0; exp = exp_q.pop_front(); vectors++;
        if (got !== exp) begin miscompares++; $display("FAIL collision_set_wins: got %h want %h", got, exp); end
        vectors++;
        if (irq0 !== 1'b0) begin miscompares++; $display("FAIL irq_unmasked_bit: got %b want 0", irq0); end
    endtask

    task automatic test_any_edge();
        @(negedge clk);
        in2 = 8'h01;
        repeat (3) @(posedge clk);
        @(negedge clk);
        in2 = 8'h00;
        repeat (4) @(posedge clk);
        exp_q.push_back(32'h0000_0001);
        do_read(3'd3);
        got = rd2; exp = exp_q.pop_front(); vectors++;
        if (got !== exp) begin miscompares++; $display("FAIL any_edgecap: got %h want %h", got, exp); end
        vectors++;
        if (irq2 !== 1'b0) begin miscompares++; $display("FAIL any_irq_masked: got %b want 0", irq2); end
        do_write(1'b0, 1'b1, 3'd2, 32'h0000_0001);
        vectors++;
        if (irq2 !== 1'b1) begin miscompares++; $display("FAIL any_irq_unmask: got %b want 1", irq2); end
        vectors++;
        if (out0 !== 8'h31) begin miscompares++; $display("FAIL cs_isolation: got %h want 31", out0); end
    endtask

    task automatic test_async_reset();
        do_read(3'd2);
        #3;
        reset_n = 1'b0;
        #1;
        vectors++;
        if (irq2 !== 1'b0) begin miscompares++; $display("FAIL areset_irq: got %b want 0", irq2); end
        vectors++;
        if (rd0 !== 32'h0 || rd2 !== 32'h0) begin miscompares++; $display("FAIL areset_readdata: got %h %h want 0 0", rd0, rd2); end
        vectors++;
        if (out0 !== 8'hA5) begin miscompares++; $display("FAIL areset_out: got %h want a5", out0); end
        in0 = 8'h00;
        in2 = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        exp_q.push_back(32'h0000_0000);
        do_read(3'd2);
        got = rd2; exp = exp_q.pop_front(); vectors++;
        if (got !== exp) begin miscompares++; $display("FAIL areset_mask: got %h want %h", got, exp); end
        exp_q.push_back(32'h0000_0000);
        do_read(3'd3);
        got = rd0 | rd2; exp = exp_q.pop_front(); vectors++;
        if (got !== exp) begin miscompares++; $display("FAIL areset_edgecap: got %h want %h", got, exp); end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset_n     = 1'b0;
        address     = 3'd0;
        cs0         = 1'b0;
        cs2         = 1'b0;
        write_n     = 1'b1;
        writedata   = 32'd0;
        in0         = 8'h00;
        in2         = 8'h00;
        test_reset();
        test_out_regs();
        test_rise_capture();
        test_clear_collision();
        test_any_edge();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
